// File: rtl/alu_md_decoder.sv
// ALU control decoder with an iterative multiply/divide unit and HI/LO registers.
// Multiply is shift-add and divide is restoring; both run on magnitudes, and the FIX state applies the signs.
module alu_md_decoder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Valid,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [2:0]       ALUControl,
  output logic             IllegalFunct,
  output logic             MdSel,
  output logic [WIDTH-1:0] MdResult,
  output logic             Busy,
  output logic             Stall
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [2:0] C_AND  = 3'b000;
  localparam logic [2:0] C_OR   = 3'b001;
  localparam logic [2:0] C_ADD  = 3'b010;
  localparam logic [2:0] C_XOR  = 3'b011;
  localparam logic [2:0] C_SLTU = 3'b100;
  localparam logic [2:0] C_NOR  = 3'b101;
  localparam logic [2:0] C_SUB  = 3'b110;
  localparam logic [2:0] C_SLT  = 3'b111;

  logic [1:0]       state;
  logic [CW-1:0]    iter;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [WIDTH-1:0] op_b;
  logic             neg_res;
  logic             neg_rem;
  logic             div_zero;
  logic             is_div;

  logic             md_funct;
  logic             md_op;
  logic             accept;
  logic             start_mul;
  logic             start_div;
  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0] quot_fixed;
  logic [WIDTH-1:0] rem_fixed;

  // Main ALU decode; unknown R-type functs fall back to AND and raise the flag.
  always_comb begin
    ALUControl   = C_ADD;
    IllegalFunct = 1'b0;
    case (ALUOp)
      2'b00: ALUControl = C_ADD;
      2'b01: ALUControl = C_SUB;
      2'b11: ALUControl = C_OR;
      default: begin
        case (Funct)
          6'b100000, 6'b100001: ALUControl = C_ADD;
          6'b100010, 6'b100011: ALUControl = C_SUB;
          6'b100100:            ALUControl = C_AND;
          6'b100101:            ALUControl = C_OR;
          6'b100110:            ALUControl = C_XOR;
          6'b100111:            ALUControl = C_NOR;
          6'b101010:            ALUControl = C_SLT;
          6'b101011:            ALUControl = C_SLTU;
          F_MFHI, F_MTHI, F_MFLO, F_MTLO,
          F_MULT, F_MULTU, F_DIV, F_DIVU: ALUControl = C_ADD;
          default: begin
            ALUControl   = C_AND;
            IllegalFunct = 1'b1;
          end
        endcase
      end
    endcase
  end

  always_comb begin
    md_funct = 1'b0;
    case (Funct)
      F_MFHI, F_MTHI, F_MFLO, F_MTLO,
      F_MULT, F_MULTU, F_DIV, F_DIVU: md_funct = 1'b1;
      default: md_funct = 1'b0;
    endcase
  end

  assign Busy      = (state != ST_IDLE);
  assign md_op     = Valid & (ALUOp == 2'b10) & md_funct;
  assign Stall     = md_op & Busy;
  assign accept    = md_op & ~Busy;
  assign start_mul = accept & ((Funct == F_MULT) | (Funct == F_MULTU));
  assign start_div = accept & ((Funct == F_DIV) | (Funct == F_DIVU));
  assign MdSel     = accept & ((Funct == F_MFHI) | (Funct == F_MFLO));

  always_comb begin
    MdResult = '0;
    if (MdSel) begin
      MdResult = (Funct == F_MFHI) ? hi : lo;
    end
  end

  // Signed variants have an even funct; unsigned ones set bit 0.
  always_comb begin
    signed_op = ~Funct[0];
    a_neg     = signed_op & SrcA[WIDTH-1];
    b_neg     = signed_op & SrcB[WIDTH-1];
    a_abs     = a_neg ? (~SrcA + 1'b1) : SrcA;
    b_abs     = b_neg ? (~SrcB + 1'b1) : SrcB;
  end

  always_comb begin
    mul_sum    = {1'b0, work_hi} + {1'b0, (work_lo[0] ? op_b : '0)};
    div_shift  = {work_hi, work_lo[WIDTH-1]};
    div_diff   = div_shift - {1'b0, op_b};
    product    = {work_hi, work_lo};
    prod_fixed = neg_res ? (~product + 1'b1) : product;
    quot_fixed = div_zero ? '1 : (neg_res ? (~work_lo + 1'b1) : work_lo);
    rem_fixed  = neg_rem ? (~work_hi + 1'b1) : work_hi;
  end

  // The most-negative / -1 case needs no special path: the magnitude quotient is
  // 2^(WIDTH-1) with no negation, which is exactly the wrapped result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      iter     <= '0;
      work_hi  <= '0;
      work_lo  <= '0;
      op_b     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      is_div   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          iter <= '0;
          if (start_mul) begin
            work_hi <= '0;
            work_lo <= b_abs;
            op_b    <= a_abs;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= 1'b0;
            div_zero <= 1'b0;
            is_div  <= 1'b0;
            state   <= ST_MUL;
          end else if (start_div) begin
            work_hi  <= '0;
            work_lo  <= a_abs;
            op_b     <= b_abs;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= (SrcB == '0);
            is_div   <= 1'b1;
            state    <= ST_DIV;
          end
        end
        ST_MUL: begin
          work_hi <= mul_sum[WIDTH:1];
          work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
          iter    <= iter + CW'(1);
          if (iter == LAST_ITER) state <= ST_FIX;
        end
        ST_DIV: begin
          if (!div_diff[WIDTH]) begin
            work_hi <= div_diff[WIDTH-1:0];
            work_lo <= {work_lo[WIDTH-2:0], 1'b1};
          end else begin
            work_hi <= div_shift[WIDTH-1:0];
            work_lo <= {work_lo[WIDTH-2:0], 1'b0};
          end
          iter <= iter + CW'(1);
          if (iter == LAST_ITER) state <= ST_FIX;
        end
        default: begin
          iter  <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // A zero divisor leaves the magnitude dividend as remainder, so only LO needs overriding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (accept && Funct == F_MTHI) begin
      hi <= SrcA;
    end else if (accept && Funct == F_MTLO) begin
      lo <= SrcA;
    end else if (state == ST_FIX) begin
      if (is_div) begin
        hi <= rem_fixed;
        lo <= quot_fixed;
      end else begin
        hi <= prod_fixed[2*WIDTH-1:WIDTH];
        lo <= prod_fixed[WIDTH-1:0];
      end
    end
  end

endmodule

// File: doc/alu_md_decoder.md
# alu_md_decoder

Parametrised successor of the single-cycle ALU decoder: decodes `ALUOp`/`Funct` into a 3-bit `ALUControl` for the main ALU, extended with xor/nor/sltu and an illegal-funct flag. Adds an iterative multiply/divide unit with HI/LO registers, covering mult, multu, div, divu, mfhi, mflo, mthi and mtlo. Asserts `Stall` to the datapath while a HI/LO-dependent instruction must wait. Sits in the ID/EX stage next to the main ALU.

## Interface
- `WIDTH`, 32: operand, HI and LO width; ≥ 4.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `Valid` in 1: instruction is issued this cycle.
- `ALUOp` in 2: from main decoder.
- `Funct` in 6: instruction funct field.
- `SrcA` in WIDTH: rs operand (dividend, multiplicand, mthi/mtlo data).
- `SrcB` in WIDTH: rt operand (divisor, multiplier).
- `ALUControl` out 3: main ALU operation; combinational.
- `IllegalFunct` out 1: R-type funct not recognised; combinational.
- `MdSel` out 1: datapath selects `MdResult` instead of the ALU result (mfhi/mflo).
- `MdResult` out WIDTH: HI for mfhi, LO for mflo, else 0; combinational.
- `Busy` out 1: multiply/divide in progress.
- `Stall` out 1: hold the issuing instruction; combinational.

## Operation
- ALUControl encoding: 000 and, 001 or, 010 add, 011 xor, 100 sltu, 101 nor, 110 sub, 111 slt.
- ALUOp decode: 00 → 010; 01 → 110; 11 → 001 (ori).
- ALUOp 10 decodes `Funct`:
  - 100000/100001 → 010; 100010/100011 → 110.
  - 100100 → 000; 100101 → 001; 100110 → 011; 100111 → 101.
  - 101010 → 111; 101011 → 100.
  - The eight MD functs (010000 mfhi, 010001 mthi, 010010 mflo, 010011 mtlo, 011000 mult, 011001 multu, 011010 div, 011011 divu) → 010, IllegalFunct 0.
  - Any other funct → 000 with IllegalFunct=1. Never X.
- MD op = `Valid` & ALUOp==10 & `Funct` is one of the eight MD functs.
- `Stall` = MD op & `Busy`. A stalled instruction has no effect; the datapath re-presents it.
- Accepted MD op (not stalled):
  - mthi/mtlo: write `SrcA` into HI/LO at the clock edge.
  - mfhi/mflo: `MdSel`=1, `MdResult` = current HI/LO.
  - mult/multu/div/divu: capture operands and start the FSM.
- FSM states and transitions:
  - IDLE → MUL (mult/multu) or DIV (div/divu).
  - MUL → FIX after WIDTH iterations (shift-add, one bit per cycle).
  - DIV → FIX after WIDTH iterations (restoring, one quotient bit per cycle).
  - FIX → IDLE, writing HI/LO.
- Iteration counter width is $clog2(WIDTH)+1.
- Signed ops: the FSM iterates on absolute values; FIX applies the sign.
  - Product: negated iff the operand signs differ; result is 2·WIDTH bits, HI = upper half, LO = lower half.
  - Quotient: negated iff the operand signs differ.
  - Remainder: takes the dividend's sign.
- div: LO = quotient, HI = remainder.
- Divide by zero (signed or unsigned): LO = all ones, HI = dividend. No exception.
- Signed overflow (−2^(WIDTH−1) / −1): LO = −2^(WIDTH−1), HI = 0.

## Timing
- Reset (async, immediate): state IDLE, HI=LO=0, counter 0, `Busy`=0. `Stall`, `MdSel` and `MdResult` are 0 unless combinationally driven by inputs.
- Reset mid-operation aborts the op; no partial HI/LO write.
- mult/div accepted in cycle 0:
  - `Busy` is high in cycles 1…WIDTH+1.
  - HI/LO are written at the end of cycle WIDTH+1.
  - mfhi/mflo issued in cycle WIDTH+2 returns the new value. Latency is 34 for WIDTH=32.
- Any MD op, including a new mult/div, issued while `Busy` stalls and does not restart or corrupt the running op.
- mthi/mtlo writes are visible to mfhi/mflo in the next cycle.
- Non-MD instructions are never stalled and decode normally while `Busy`.

## Test plan
- **ALU decode:**
  - ALUOp 00 → 010; 01 → 110; 11 → 001.
  - ALUOp 10 with Funct 100111 → 101, 101011 → 100.
  - Funct 111111 → 000 with IllegalFunct=1.
- **Multiply (WIDTH=32), SrcA=0xFFFFFFFD, SrcB=7:**
  - mult → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - multu → HI=0x00000006, LO=0xFFFFFFEB.
  - Busy high exactly 33 cycles for each.
- **Divide:**
  - div −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7/0 → LO=0xFFFFFFFF, HI=7.
  - div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- **Stall:** mflo issued in cycle 5 after mult → Stall=1 in cycles 5…33; in cycle 34 Stall=0, MdSel=1, MdResult = new LO. A second mult issued in cycle 3 is stalled and does not restart the first.
- **Reset:** reset pulsed in cycle 10 of a div → Busy=0, HI=LO=0 without waiting for a clock edge. A following mfhi returns 0.
- **Move to/from HI/LO:** mthi 0x12345678 then mfhi next cycle → MdResult=0x12345678. mtlo 0xCAFEBABE then mflo → 0xCAFEBABE.
